// File: rtl/sd_write_result.sv
// sd_write_result
// Copies a contiguous DDR region (16-bit words) to consecutive SD sectors.
// Each sector is first prefetched from DDR into a one-sector buffer. The
// buffer is then streamed to the SD write controller, one word per wr_req.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   dump_start/dump_len start pulse and word count (sampled when accepted)
//   ddr_rd_*            DDR word read request/response (in-order, latency >= 1)
//   wr_start_en         one-cycle start of a sector write at wr_sec_addr
//   wr_busy/wr_req      SD controller busy flag and per-word data request
//   wr_data             data word presented to the SD controller
//   dump_busy/dump_done dump in progress / one-cycle completion pulse
module sd_write_result #(
  parameter logic [31:0] RESULT_ADDR_START = 32'd131072,
  parameter int          SEC_WORDS         = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dump_start,
  input  logic [23:0] dump_len,
  output logic        ddr_rd_en,
  output logic [23:0] ddr_rd_addr,
  input  logic        ddr_rd_valid,
  input  logic [15:0] ddr_rd_data,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic [15:0] wr_data,
  output logic        dump_busy,
  output logic        dump_done
);

  localparam int SHIFT = $clog2(SEC_WORDS);
  localparam int CW    = SHIFT + 1;  // counters must be able to hold SEC_WORDS itself
  localparam logic [CW-1:0] SEC_C = CW'(SEC_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_r, state_next_s;

  logic [23:0]   len_r;
  logic [23:0]   nsec_r;
  logic [23:0]   sec_cnt_r;
  logic [23:0]   ptr_r;          // next DDR word address, global across sectors
  logic [CW-1:0] sec_words_r;    // real (non-padding) words in the current sector
  logic [CW-1:0] req_cnt_r;
  logic [CW-1:0] recv_cnt_r;
  logic [CW-1:0] rd_cnt_r;
  logic          busy_d0_r;
  logic          busy_d1_r;

  logic          ddr_rd_en_r;
  logic [23:0]   ddr_rd_addr_r;
  logic          wr_start_en_r;
  logic [31:0]   wr_sec_addr_r;
  logic [15:0]   wr_data_r;
  logic          dump_busy_r;
  logic          dump_done_r;

  logic [15:0]   buf_r [SEC_WORDS];

  logic          accept_s;
  logic          zero_len_s;
  logic          issue_s;
  logic          fill_full_s;
  logic          sec_edge_s;
  logic          last_sec_s;
  logic [24:0]   len_round_s;
  logic [23:0]   nsec_s;
  logic [23:0]   rem_s;
  logic [CW-1:0] first_words_s;
  logic [CW-1:0] next_words_s;
  logic          buf_we_s;
  logic [15:0]   buf_wd_s;

  assign ddr_rd_en   = ddr_rd_en_r;
  assign ddr_rd_addr = ddr_rd_addr_r;
  assign wr_start_en = wr_start_en_r;
  assign wr_sec_addr = wr_sec_addr_r;
  assign wr_data     = wr_data_r;
  assign dump_busy   = dump_busy_r;
  assign dump_done   = dump_done_r;

  // Control decodes, sector count and per-sector real word count.
  always_comb begin
    accept_s      = (state_r == S_IDLE) && dump_start && (dump_len != 24'd0);
    zero_len_s    = (state_r == S_IDLE) && dump_start && (dump_len == 24'd0);
    issue_s       = (state_r == S_FILL) && (req_cnt_r < sec_words_r);
    fill_full_s   = (state_r == S_FILL) && (recv_cnt_r == SEC_C);
    // Falling edge of wr_busy, only meaningful after this sector's start pulse
    sec_edge_s    = (state_r == S_WAIT) && busy_d1_r && !busy_d0_r;
    last_sec_s    = (sec_cnt_r == (nsec_r - 24'd1));
    // One extra bit so dump_len near 2^24 cannot overflow the round-up
    len_round_s   = {1'b0, dump_len} + 25'(SEC_WORDS - 1);
    nsec_s        = 24'(len_round_s >> SHIFT);
    rem_s         = len_r - ptr_r;
    first_words_s = (dump_len >= 24'(SEC_WORDS)) ? SEC_C : dump_len[CW-1:0];
    next_words_s  = (rem_s >= 24'(SEC_WORDS)) ? SEC_C : rem_s[CW-1:0];
  end

  // Buffer write port: DDR returns first, then zero padding up to a full sector.
  always_comb begin
    buf_we_s = 1'b0;
    buf_wd_s = 16'h0000;
    if (state_r == S_FILL) begin
      if (recv_cnt_r < sec_words_r) begin
        if (ddr_rd_valid) begin
          buf_we_s = 1'b1;
          buf_wd_s = ddr_rd_data;
        end else begin
          buf_we_s = 1'b0;
        end
      end else if (recv_cnt_r < SEC_C) begin
        buf_we_s = 1'b1;
        buf_wd_s = 16'h0000;
      end else begin
        buf_we_s = 1'b0;
      end
    end else begin
      buf_we_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = S_FILL;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (fill_full_s) begin
          state_next_s = S_WRITE;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_WRITE: state_next_s = S_WAIT;
      S_WAIT: begin
        if (sec_edge_s) begin
          state_next_s = last_sec_s ? S_DONE : S_FILL;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // wr_busy falling-edge pipeline; cleared at the start pulse so older edges are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_d0_r <= 1'b0;
      busy_d1_r <= 1'b0;
    end else if (state_r == S_WRITE) begin
      busy_d0_r <= 1'b0;
      busy_d1_r <= 1'b0;
    end else begin
      busy_d0_r <= wr_busy;
      busy_d1_r <= busy_d0_r;
    end
  end

  // Sector buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_r[recv_cnt_r[CW-2:0]] <= buf_wd_s;
    end
  end

  // Datapath: counters, DDR requests, SD handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r         <= 24'd0;
      nsec_r        <= 24'd0;
      sec_cnt_r     <= 24'd0;
      ptr_r         <= 24'd0;
      sec_words_r   <= '0;
      req_cnt_r     <= '0;
      recv_cnt_r    <= '0;
      rd_cnt_r      <= '0;
      ddr_rd_en_r   <= 1'b0;
      ddr_rd_addr_r <= 24'd0;
      wr_start_en_r <= 1'b0;
      wr_sec_addr_r <= 32'd0;
      wr_data_r     <= 16'h0000;
      dump_busy_r   <= 1'b0;
      dump_done_r   <= 1'b0;
    end else begin
      ddr_rd_en_r   <= 1'b0;
      wr_start_en_r <= 1'b0;
      dump_done_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            len_r         <= dump_len;
            nsec_r        <= nsec_s;
            sec_cnt_r     <= 24'd0;
            ptr_r         <= 24'd0;
            sec_words_r   <= first_words_s;
            req_cnt_r     <= '0;
            recv_cnt_r    <= '0;
            rd_cnt_r      <= '0;
            wr_sec_addr_r <= RESULT_ADDR_START;
            dump_busy_r   <= 1'b1;
          end else if (zero_len_s) begin
            dump_done_r <= 1'b1;
          end else begin
            dump_done_r <= 1'b0;
          end
        end
        S_FILL: begin
          if (issue_s) begin
            ddr_rd_en_r   <= 1'b1;
            ddr_rd_addr_r <= ptr_r;
            ptr_r         <= ptr_r + 24'd1;
            req_cnt_r     <= req_cnt_r + CW'(1);
          end
          if (buf_we_s) begin
            recv_cnt_r <= recv_cnt_r + CW'(1);
          end
          if (fill_full_s) begin
            wr_start_en_r <= 1'b1;
          end
        end
        S_WRITE, S_WAIT: begin
          if (wr_req) begin
            if (rd_cnt_r < SEC_C) begin
              wr_data_r <= buf_r[rd_cnt_r[CW-2:0]];
              rd_cnt_r  <= rd_cnt_r + CW'(1);
            end else begin
              // Requests beyond the sector get zeros; the counter saturates
              wr_data_r <= 16'h0000;
            end
          end
          if (sec_edge_s) begin
            sec_cnt_r     <= sec_cnt_r + 24'd1;
            wr_sec_addr_r <= wr_sec_addr_r + 32'd1;
            if (last_sec_s) begin
              dump_busy_r <= 1'b0;
              dump_done_r <= 1'b1;
            end else begin
              req_cnt_r   <= '0;
              recv_cnt_r  <= '0;
              rd_cnt_r    <= '0;
              sec_words_r <= next_words_s;
            end
          end
        end
        S_DONE: begin
          dump_busy_r <= 1'b0;
        end
        default: begin
          dump_busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_write_result.sv
// Self-checking bench for sd_write_result: a DDR responder with configurable
// latency and gaps, plus an SD controller model, driven from tasks. Expected
// words come from a reference rule: word i of sector s is DDR word s*256+i
// when that index is below dump_len, and zero otherwise.
module tb_sd_write_result;

  localparam logic [31:0] START = 32'd131072;

  logic        clk;
  logic        rst_n;
  logic        dump_start;
  logic [23:0] dump_len;
  logic        ddr_rd_en;
  logic [23:0] ddr_rd_addr;
  logic        ddr_rd_valid;
  logic [15:0] ddr_rd_data;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        dump_busy;
  logic        dump_done;

  sd_write_result dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_start   (dump_start),
    .dump_len     (dump_len),
    .ddr_rd_en    (ddr_rd_en),
    .ddr_rd_addr  (ddr_rd_addr),
    .ddr_rd_valid (ddr_rd_valid),
    .ddr_rd_data  (ddr_rd_data),
    .wr_start_en  (wr_start_en),
    .wr_sec_addr  (wr_sec_addr),
    .wr_busy      (wr_busy),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .dump_busy    (dump_busy),
    .dump_done    (dump_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Shared configuration written by the main flow
  logic [15:0] key     = 16'h0000;
  int          cur_len = 0;
  int          lat_cfg = 3;
  bit          gaps_cfg = 1'b0;

  // Statistics owned by the DDR responder
  int n_req     = 0;
  int addr_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ddr_word(input int addr);
    logic [15:0] a;
    a = 16'(addr);
    return a ^ key;
  endfunction

  function automatic logic [15:0] exp_word(input int len, input int s, input int i);
    int idx;
    idx = s * 256 + i;
    return (idx < len) ? ddr_word(idx) : 16'h0000;
  endfunction

  // DDR responder: logs requests, checks the address stream, returns data in order.
  initial begin : ddr_model
    int pend_t[$];
    int pend_a[$];
    int dcyc;
    int next_addr;
    dcyc = 0;
    next_addr = 0;
    ddr_rd_valid = 1'b0;
    ddr_rd_data  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      dcyc++;
      if (!rst_n) begin
        pend_t.delete();
        pend_a.delete();
        ddr_rd_valid = 1'b0;
        next_addr = 0;
      end else begin
        if (!dump_busy) next_addr = 0;
        if (ddr_rd_en) begin
          if ((int'(ddr_rd_addr) != next_addr) || (next_addr >= cur_len)) addr_errs++;
          pend_t.push_back(dcyc);
          pend_a.push_back(int'(ddr_rd_addr));
          next_addr++;
          n_req++;
        end
        if ((pend_t.size() > 0) && ((dcyc - pend_t[0]) >= lat_cfg) &&
            (!gaps_cfg || ($urandom_range(0, 2) != 0))) begin
          ddr_rd_valid = 1'b1;
          ddr_rd_data  = ddr_word(pend_a[0]);
          void'(pend_t.pop_front());
          void'(pend_a.pop_front());
        end else begin
          ddr_rd_valid = 1'b0;
        end
      end
    end
  end

  // SD controller model for one sector; optionally resets the DUT at word abort_at.
  task automatic do_sector(input int s, input int maxsp, input bit extra, input bit midstart,
                           input int abort_at, output bit aborted);
    aborted = 1'b0;
    check($sformatf("sec_addr s%0d", s), wr_sec_addr, START + 32'(s));
    @(posedge clk); #1;
    check("start_pulse_width", {31'd0, wr_start_en}, 32'd0);
    wr_busy = 1'b1;
    if (midstart) begin
      dump_len = 24'd5;
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      dump_len = 24'(cur_len);
      check("busy_after_restart", {31'd0, dump_busy}, 32'd1);
    end
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = int'($urandom_range(0, maxsp - 1));
      repeat (gap) begin @(posedge clk); #1; end
      if (i == abort_at) begin
        rst_n = 1'b0;
        wr_req = 1'b0;
        wr_busy = 1'b0;
        #1;
        check("rst_ddr_rd_en", {31'd0, ddr_rd_en}, 32'd0);
        check("rst_wr_start_en", {31'd0, wr_start_en}, 32'd0);
        check("rst_wr_sec_addr", wr_sec_addr, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_dump_busy", {31'd0, dump_busy}, 32'd0);
        check("rst_dump_done", {31'd0, dump_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      wr_req = 1'b1;
      @(posedge clk); #1;
      wr_req = 1'b0;
      check($sformatf("wr_data s%0d w%0d", s, i), {16'd0, wr_data}, {16'd0, exp_word(cur_len, s, i)});
    end
    if (extra) begin
      wr_req = 1'b1;
      @(posedge clk); #1;
      wr_req = 1'b0;
      check("wr_data_past_end", {16'd0, wr_data}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    wr_busy = 1'b0;
  endtask

  // One complete dump with the chosen stimulus options.
  task automatic run_dump(input int len, input int lat, input bit gaps, input int maxsp,
                          input bit extra, input bit midstart, input bit glitch,
                          input int abort_at, input logic [15:0] k);
    int  req0, err0, nexp, sec, cyc, starts, ens;
    bit  done_seen, aborted;
    key = k;
    cur_len = len;
    lat_cfg = lat;
    gaps_cfg = gaps;
    req0 = n_req;
    err0 = addr_errs;
    nexp = (len + 255) / 256;
    dump_len = 24'(len);
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    if (len == 0) begin
      check("zero_len_done", {31'd0, dump_done}, 32'd1);
      check("zero_len_busy", {31'd0, dump_busy}, 32'd0);
      starts = 0;
      ens = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (c == 0) check("zero_len_done_width", {31'd0, dump_done}, 32'd0);
        starts += int'(wr_start_en);
        ens += int'(ddr_rd_en);
      end
      check("zero_len_ddr_en", 32'(ens), 32'd0);
      check("zero_len_wr_start", 32'(starts), 32'd0);
      check("zero_len_req_total", 32'(n_req - req0), 32'd0);
      return;
    end
    check("busy_after_start", {31'd0, dump_busy}, 32'd1);
    if (glitch) begin
      repeat (20) @(posedge clk);
      #1;
      wr_busy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      wr_busy = 1'b0;
    end
    sec = 0;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && (cyc < 60000)) begin
      if (wr_start_en) begin
        do_sector(sec, maxsp, extra, midstart && (sec == 1),
                  (sec == 1) ? abort_at : -1, aborted);
        if (aborted) return;
        sec++;
      end else if (dump_done) begin
        done_seen = 1'b1;
        check("busy_low_at_done", {31'd0, dump_busy}, 32'd0);
      end
      if (!done_seen) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("dump_done_seen", {31'd0, done_seen}, 32'd1);
    check("sector_count", 32'(sec), 32'(nexp));
    check("final_sec_addr", wr_sec_addr, START + 32'(nexp));
    check("ddr_req_total", 32'(n_req - req0), 32'(len));
    check("ddr_addr_errors", 32'(addr_errs - err0), 32'd0);
    @(posedge clk); #1;
    check("done_width", {31'd0, dump_done}, 32'd0);
    check("busy_after_done", {31'd0, dump_busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    dump_start = 1'b0;
    dump_len = 24'd0;
    wr_busy = 1'b0;
    wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ddr_rd_en", {31'd0, ddr_rd_en}, 32'd0);
    check("reset_wr_sec_addr", wr_sec_addr, 32'd0);
    check("reset_dump_busy", {31'd0, dump_busy}, 32'd0);
    check("reset_dump_done", {31'd0, dump_done}, 32'd0);
    check("reset_wr_data", {16'd0, wr_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Exactly one sector, data = address, plus a request past the end
    run_dump(256, 3, 1'b0, 1, 1'b1, 1'b0, 1'b0, -1, 16'h0000);
    // Partial last sector with zero padding
    run_dump(300, 2, 1'b0, 2, 1'b0, 1'b0, 1'b0, -1, 16'(($urandom)));
    // Zero-length dump
    run_dump(0, 3, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1, 16'h0000);
    // Random DDR gaps and wr_req spacing, with a start pulse mid-run
    run_dump(1024, 4, 1'b1, 8, 1'b0, 1'b1, 1'b0, -1, 16'(($urandom)));
    // Reset during sector 2 WRITE, then a fresh dump
    run_dump(1024, 3, 1'b1, 3, 1'b0, 1'b0, 1'b0, 100, 16'(($urandom)));
    repeat (10) @(posedge clk);
    #1;
    run_dump(256, 5, 1'b1, 2, 1'b0, 1'b0, 1'b0, -1, 16'(($urandom)));
    // wr_busy glitch during FILL must not count as a sector completion
    run_dump(600, 1, 1'b1, 2, 1'b0, 1'b0, 1'b1, -1, 16'(($urandom)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
